line_raster: RTL
================

LINE_RASTER -- requirements
Module: line_raster

Interface
REQ-001 The block SHALL have parameter CW, default 8, the coordinate width in bits for all x/y ports.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port go, input, 1 bit, a line request, accepted only while busy=0.
REQ-005 The block SHALL have ports stax, stay, endx, endy, input, CW bits each, unsigned start/end coordinates, sampled on the go-accept cycle.
REQ-006 The block SHALL have port busy, output, 1 bit; high from the cycle after go-accept until the last pixel handshake.
REQ-007 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the last pixel is accepted.
REQ-008 The block SHALL have port wr, output, 1 bit, meaning pixel valid.
REQ-009 The block SHALL have port ready, input, 1 bit, downstream pixel acceptance; a pixel transfers when wr&ready.
REQ-010 The block SHALL have ports xout, yout, output, CW bits each, the current pixel coordinate.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; no other state SHALL be reachable, and any illegal encoding SHALL go to IDLE.
REQ-012 IDLE SHALL move to RUN on go, latching coordinates, x=stax, y=stay, dx=|endx-stax|, dy=-|endy-stay|, err=dx+dy, sx/sy = +1/-1 step directions.
REQ-013 RUN SHALL assert wr=1 with xout/yout = current (x,y).
REQ-014 In RUN with ready=0, all state, wr and xout/yout SHALL hold unchanged.
REQ-015 In RUN with ready=1 and (x,y)==(endx,endy) latched, the FSM SHALL go to DONE.
REQ-016 In RUN with ready=1 otherwise, the block SHALL take one Bresenham step with e2=2*err.
- if e2>=dy: err+=dy, x+=sx
- if e2<=dx: err+=dx, y+=sy
- both updates use the pre-step err.
REQ-017 The line SHALL emit exactly max(|dx|,|dy|)+1 pixels, in order from start to end inclusive, with no overshoot and no duplicate pixels.
REQ-018 In DONE, done SHALL be 1 and wr 0 for exactly one cycle; the FSM then goes to RUN if go=1 (new line accepted, busy low that cycle), else to IDLE.
REQ-019 go SHALL be ignored while busy=1.
REQ-020 Deltas SHALL be computed signed at CW+1 bits and err held signed at CW+2 bits, so no overflow occurs for any endpoint pair, including 0 to 2^CW-1.
REQ-021 A zero-length line (start==end) SHALL emit one pixel and then pulse done.
REQ-022 Latency SHALL be: first wr on the cycle after go-accept; with ready held 1, one pixel per cycle, and done one cycle after the last pixel.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL load state IDLE, wr=0, busy=0, done=0, xout=0, yout=0, err=0, and the dash counter (if present) 0.
REQ-024 rst SHALL take priority over go and ready; reset mid-line SHALL abort the line with no done pulse, and wr SHALL be 0 from the next cycle.

Configuration
REQ-025 With macro LINE_RASTER_DASH_EN defined, the block SHALL add input dash_pat [7:0], latched on go-accept, and a 3-bit step index reset to 0 at go-accept.
- In RUN, wr = dash_pat[index]; the index increments on every Bresenham step.
- A pixel with pattern bit 0 SHALL still advance one step per cycle regardless of ready.
- Pixel order and end detection are unchanged.
REQ-026 Without LINE_RASTER_DASH_EN, the dash_pat port and index SHALL NOT exist, and behaviour SHALL equal dash_pat=8'hFF.

Verification
REQ-027 CW=8, ready=1, go with (0,0)->(5,0): SHALL give wr for 6 cycles with x=0..5, y=0, then done for 1 cycle.
REQ-028 Steep negative line (10,20)->(7,10), ready=1: SHALL give 11 pixels with y strictly decrementing, x 10 down to 7 monotonically, and last pixel (7,10).
REQ-029 Zero-length line (42,42): SHALL give exactly one wr with (42,42), then done on the next cycle.
REQ-030 (0,0)->(255,255) with ready toggling 1,0,1,0: SHALL give 256 distinct pixels, each held while ready=0, and no wraparound.
REQ-031 rst asserted on the 3rd pixel of (0,0)->(9,3): SHALL give wr=0 and busy=0 next cycle, and no done pulse; a following go SHALL then start cleanly.
REQ-032 With LINE_RASTER_DASH_EN, dash_pat=8'b00001111, (0,0)->(15,0): SHALL give wr only for x=0-3 and 8-11, and done after the x=15 step.

Source files
------------

// File: rtl/line_raster.sv
// Bresenham line rasteriser: one pixel per accepted handshake, done pulse after the last one.
// Optional feature: define LINE_RASTER_DASH_EN to add an 8-bit dash pattern input.
module line_raster #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [CW-1:0] stax,
  input  logic [CW-1:0] stay,
  input  logic [CW-1:0] endx,
  input  logic [CW-1:0] endy,
`ifdef LINE_RASTER_DASH_EN
  input  logic [7:0]    dash_pat,
`endif
  output logic          busy,
  output logic          done,
  output logic          wr,
  input  logic          ready,
  output logic [CW-1:0] xout,
  output logic [CW-1:0] yout
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t                state_r, state_s;
  logic [CW-1:0]         x_r, y_r, ex_r, ey_r;
  logic [CW-1:0]         x_s, y_s, ex_s, ey_s;
  logic signed [CW:0]    dx_r, dy_r, dx_s, dy_s;
  logic signed [CW+1:0]  err_r, err_s;
  logic                  sxn_r, syn_r, sxn_s, syn_s;
  logic                  wr_r, busy_r, done_r;
  logic                  wr_s, busy_s, done_s;
  logic                  accept_s, advance_s, at_end_s;
  logic signed [CW+2:0]  e2_s, dx_e_s, dy_e_s;
  logic signed [CW:0]    ddx_s, ddy_s;
`ifdef LINE_RASTER_DASH_EN
  logic [7:0]            pat_r, pat_s;
  logic [2:0]            idx_r, idx_s;
`endif

  // Signed difference a-b, one bit wider so 0 vs 2^CW-1 cannot overflow.
  function automatic logic signed [CW:0] sdiff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic signed [CW:0] sabs(input logic signed [CW:0] d);
    if (d[CW]) begin
      return -d;
    end else begin
      return d;
    end
  endfunction

  // Next-state, datapath step and next output values.
  always_comb begin
    state_s   = state_r;
    x_s       = x_r;
    y_s       = y_r;
    ex_s      = ex_r;
    ey_s      = ey_r;
    dx_s      = dx_r;
    dy_s      = dy_r;
    err_s     = err_r;
    sxn_s     = sxn_r;
    syn_s     = syn_r;
    accept_s  = 1'b0;
    ddx_s     = sdiff(endx, stax);
    ddy_s     = sdiff(endy, stay);
    e2_s      = $signed({err_r[CW+1], err_r, 1'b0});
    dx_e_s    = $signed({{2{dx_r[CW]}}, dx_r});
    dy_e_s    = $signed({{2{dy_r[CW]}}, dy_r});
    at_end_s  = (x_r == ex_r) && (y_r == ey_r);
`ifdef LINE_RASTER_DASH_EN
    pat_s     = pat_r;
    idx_s     = idx_r;
    // Blanked pixels are never presented, so they need no handshake.
    advance_s = ready | ~pat_r[idx_r];
`else
    advance_s = ready;
`endif

    case (state_r)
      IDLE: begin
        if (go) begin
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (advance_s && at_end_s) begin
          state_s = DONE;
        end else if (advance_s) begin
          // Both tests use the pre-step error term.
          if (e2_s >= dy_e_s) begin
            err_s = err_s + $signed({dy_r[CW], dy_r});
            x_s   = sxn_r ? (x_r - ONE) : (x_r + ONE);
          end else begin
            x_s   = x_r;
          end
          if (e2_s <= dx_e_s) begin
            err_s = err_s + $signed({dx_r[CW], dx_r});
            y_s   = syn_r ? (y_r - ONE) : (y_r + ONE);
          end else begin
            y_s   = y_r;
          end
`ifdef LINE_RASTER_DASH_EN
          idx_s = idx_r + 3'd1;
`endif
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (go) begin
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (accept_s) begin
      state_s = RUN;
      x_s     = stax;
      y_s     = stay;
      ex_s    = endx;
      ey_s    = endy;
      dx_s    = sabs(ddx_s);
      dy_s    = -sabs(ddy_s);
      err_s   = $signed({dx_s[CW], dx_s}) + $signed({dy_s[CW], dy_s});
      sxn_s   = ddx_s[CW];
      syn_s   = ddy_s[CW];
`ifdef LINE_RASTER_DASH_EN
      pat_s   = dash_pat;
      idx_s   = 3'd0;
`endif
    end else begin
      accept_s = 1'b0;
    end

    busy_s = (state_s == RUN);
    done_s = (state_s == DONE);
`ifdef LINE_RASTER_DASH_EN
    wr_s   = (state_s == RUN) & pat_s[idx_s];
`else
    wr_s   = (state_s == RUN);
`endif
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      x_r     <= {CW{1'b0}};
      y_r     <= {CW{1'b0}};
      ex_r    <= {CW{1'b0}};
      ey_r    <= {CW{1'b0}};
      dx_r    <= {(CW+1){1'b0}};
      dy_r    <= {(CW+1){1'b0}};
      err_r   <= {(CW+2){1'b0}};
      sxn_r   <= 1'b0;
      syn_r   <= 1'b0;
      wr_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef LINE_RASTER_DASH_EN
      pat_r   <= 8'h00;
      idx_r   <= 3'd0;
`endif
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
      ex_r    <= ex_s;
      ey_r    <= ey_s;
      dx_r    <= dx_s;
      dy_r    <= dy_s;
      err_r   <= err_s;
      sxn_r   <= sxn_s;
      syn_r   <= syn_s;
      wr_r    <= wr_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
`ifdef LINE_RASTER_DASH_EN
      pat_r   <= pat_s;
      idx_r   <= idx_s;
`endif
    end
  end

  assign wr   = wr_r;
  assign busy = busy_r;
  assign done = done_r;
  assign xout = x_r;
  assign yout = y_r;

endmodule
